// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte producers, the baud strobe source and the
// shared-UART arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic                 clk_baud;
  logic [N_REQ-1:0]     req;
  logic [8*N_REQ-1:0]   data_in;
  logic [N_REQ-1:0]     ack;
  logic [N_REQ-1:0]     grant;
  logic                 busy;
  logic                 start;
  logic [7:0]           data_out;
  logic                 done;

  // Producer / transmitter side.
  modport master (
    output clk_baud, req, data_in,
    input  ack, grant, busy, start, data_out, done
  );

  // Arbiter side.
  modport slave (
    input  clk_baud, req, data_in,
    output ack, grant, busy, start, data_out, done
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte producers;
// times each frame plus a guard gap by counting baud strobes.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned FRAME_TICKS = 160,
  parameter int unsigned GUARD_TICKS = 16
) (
  input logic              clk_in,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned MaxTicks = (FRAME_TICKS > GUARD_TICKS) ? FRAME_TICKS : GUARD_TICKS;
  localparam int unsigned CW       = $clog2(MaxTicks + 1);
  localparam int unsigned IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StGuard = 2'd3;

  localparam logic [CW-1:0] FrameLast = CW'(FRAME_TICKS - 1);
  localparam logic [CW-1:0] GuardLast = CW'((GUARD_TICKS == 0) ? 0 : GUARD_TICKS - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             start_q, start_d;
  logic [7:0]       data_q, data_d;
  logic             done_q, done_d;

  logic             win_found;
  logic [IW-1:0]    win_idx;
  logic [7:0]       win_byte;
  logic             exit_frame;

  // First set request searching upward from last winner + 1, with wrap.
  always_comb begin
    int unsigned   idx;
    logic [IW-1:0] idx_t;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    idx_t     = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx   = (int'(last_q) + k) % N_REQ;
      idx_t = IW'(idx);
      if (!win_found && bus.req[idx_t]) begin
        win_found = 1'b1;
        win_idx   = idx_t;
      end
    end
  end

  always_comb begin
    win_byte = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (win_idx == IW'(i)) begin
        win_byte = bus.data_in[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    owner_d    = owner_q;
    ack_d      = '0;
    grant_d    = grant_q;
    busy_d     = busy_q;
    start_d    = 1'b0;
    data_d     = data_q;
    done_d     = 1'b0;
    exit_frame = 1'b0;

    case (state_q)
      StIdle: begin
        if (win_found) begin
          ack_d[win_idx]   = 1'b1;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          busy_d           = 1'b1;
          data_d           = win_byte;
          owner_d          = win_idx;
          cnt_d            = '0;
          state_d          = StStart;
        end
      end
      StStart: begin
        start_d = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        if (bus.clk_baud) begin
          if (cnt_q == FrameLast) begin
            cnt_d = '0;
            if (GUARD_TICKS == 0) begin
              exit_frame = 1'b1;
            end else begin
              state_d = StGuard;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StGuard: begin
        if (bus.clk_baud) begin
          if (cnt_q == GuardLast) begin
            exit_frame = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A terminal-count strobe is consumed here; the counter restarts clean.
    if (exit_frame) begin
      state_d = StIdle;
      cnt_d   = '0;
      busy_d  = 1'b0;
      grant_d = '0;
      done_d  = 1'b1;
      last_d  = owner_q;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      last_q  <= IW'(N_REQ - 1);
      owner_q <= '0;
      ack_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      ack_q   <= ack_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.grant    = grant_q;
  assign bus.busy     = busy_q;
  assign bus.start    = start_q;
  assign bus.data_out = data_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised bench for uart_tx_arbiter against a transaction-level model that
// tracks only the owner and the strobes left in frame plus guard.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int F = 160;
  localparam int G = 16;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;

  always #5 clk_in = ~clk_in;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(
    .N_REQ      (N),
    .FRAME_TICKS(F),
    .GUARD_TICKS(G)
  ) dut (
    .clk_in(clk_in),
    .rst   (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model state.
  int             m_owner;
  int             m_left;
  int             m_last;
  bit             m_in_start;
  logic [7:0]     m_data;
  logic [N-1:0]   e_ack, e_grant;
  logic           e_busy, e_start, e_done;

  task automatic model_reset();
    m_owner    = -1;
    m_left     = 0;
    m_last     = N - 1;
    m_in_start = 1'b0;
    m_data     = '0;
    e_ack      = '0;
    e_grant    = '0;
    e_busy     = 1'b0;
    e_start    = 1'b0;
    e_done     = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [8*N-1:0] d, input logic b);
    e_ack   = '0;
    e_start = 1'b0;
    e_done  = 1'b0;
    if (m_owner < 0) begin
      if (r != '0) begin
        for (int k = 1; k <= N; k++) begin
          int idx;
          idx = (m_last + k) % N;
          if (r[idx]) begin
            m_owner = idx;
            break;
          end
        end
        e_ack[m_owner] = 1'b1;
        m_data         = d[8*m_owner +: 8];
        m_in_start     = 1'b1;
        m_left         = F + G;
      end
    end else if (m_in_start) begin
      e_start    = 1'b1;
      m_in_start = 1'b0;
    end else if (b) begin
      m_left--;
      if (m_left == 0) begin
        e_done  = 1'b1;
        m_last  = m_owner;
        m_owner = -1;
      end
    end
    e_busy  = (m_owner >= 0);
    e_grant = '0;
    if (m_owner >= 0) e_grant[m_owner] = 1'b1;
  endtask

  task automatic check_outputs();
    check_eq("ack",      32'(bus.ack),      32'(e_ack));
    check_eq("grant",    32'(bus.grant),    32'(e_grant));
    check_eq("busy",     32'(bus.busy),     32'(e_busy));
    check_eq("start",    32'(bus.start),    32'(e_start));
    check_eq("data_out", 32'(bus.data_out), 32'(m_data));
    check_eq("done",     32'(bus.done),     32'(e_done));
  endtask

  task automatic step(input logic [N-1:0] r, input logic [8*N-1:0] d, input logic b);
    @(negedge clk_in);
    bus.req      = r;
    bus.data_in  = d;
    bus.clk_baud = b;
    @(posedge clk_in);
    #1;
    model_step(r, d, b);
    check_outputs();
  endtask

  // Asynchronous reset between clock edges; outputs must clear without a clock.
  task automatic do_reset();
    @(negedge clk_in);
    bus.req      = '0;
    bus.clk_baud = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk_in);
    #1;
    check_outputs();
    @(negedge clk_in);
    rst = 1'b0;
  endtask

  function automatic logic [8*N-1:0] rand_data();
    logic [8*N-1:0] d;
    for (int i = 0; i < N; i++) d[8*i +: 8] = 8'($urandom);
    return d;
  endfunction

  // Steps until the model reports done; counts strobes that fell inside the frame.
  task automatic run_until_done(input logic [N-1:0] r, input int baud_pct, input bit rand_req,
                                output int strobes);
    bit finished;
    strobes  = 0;
    finished = 1'b0;
    for (int c = 0; c < 4000 && !finished; c++) begin
      logic           b;
      logic [N-1:0]   rr;
      b  = ($urandom_range(0, 99) < baud_pct);
      rr = rand_req ? N'($urandom) : r;
      if (m_owner >= 0 && !m_in_start && b) strobes++;
      step(rr, rand_data(), b);
      finished = e_done;
    end
    if (!finished) check_eq("timeout_done", 32'd0, 32'd1);
  endtask

  initial begin
    int             strobes;
    int             n_acks;
    logic [N-1:0]   order [5];
    logic [8*N-1:0] d;
    logic [N-1:0]   r;

    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.req      = '0;
    bus.data_in  = '0;
    bus.clk_baud = 1'b0;
    model_reset();
    do_reset();

    // Single request, byte A5 from requester 1; wanders req/data during the frame.
    step(4'b0010, {16'h0000, 8'hA5, 8'h00}, 1'b0);
    check_eq("single_data", 32'(bus.data_out), 32'h0000_00A5);
    step(4'b0000, rand_data(), 1'b0);
    run_until_done('0, 50, 1'b1, strobes);
    check_eq("single_strobes", 32'(strobes), 32'(F + G));

    // Strobes during acceptance and START are not counted.
    do_reset();
    step(4'b0010, rand_data(), 1'b1);
    step(4'b0000, rand_data(), 1'b1);
    run_until_done('0, 100, 1'b0, strobes);
    check_eq("edge_strobes", 32'(strobes), 32'(F + G));

    // All requesters held: round-robin order 0,1,2,3,0.
    do_reset();
    n_acks = 0;
    for (int c = 0; c < 5000 && n_acks < 5; c++) begin
      step(4'b1111, rand_data(), ($urandom_range(0, 3) != 0));
      if (e_ack != '0) begin
        check_eq("rr_order", 32'(bus.grant), 32'(order[n_acks]));
        n_acks++;
      end
    end
    check_eq("rr_count", 32'(n_acks), 32'd5);

    // Requester 2 keeps req across its done while 3 waits: 3 goes next.
    do_reset();
    step(4'b0100, rand_data(), 1'b0);
    run_until_done(4'b1100, 70, 1'b0, strobes);
    step(4'b1100, rand_data(), 1'b0);
    check_eq("rr_skip_holder", 32'(bus.grant), 32'h8);

    // Reset at strobe 80 of a frame owned by requester 1.
    do_reset();
    step(4'b0010, rand_data(), 1'b0);
    step(4'b0000, rand_data(), 1'b0);
    for (int s = 0; s < 80; s++) step(4'b0000, rand_data(), 1'b1);
    do_reset();
    step(4'b1111, rand_data(), 1'b0);
    check_eq("post_reset_tie", 32'(bus.grant), 32'h1);
    do_reset();
    step(4'b1000, rand_data(), 1'b0);
    check_eq("post_reset_req3", 32'(bus.grant), 32'h8);
    run_until_done('0, 60, 1'b0, strobes);

    // Random traffic with persistent, occasionally flipping requests.
    r = '0;
    for (int c = 0; c < 20000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
      d = rand_data();
      step(r, d, ($urandom_range(0, 1) == 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
